data_receiver: RTL and testbench
================================

// Module: data_receiver
// PURPOSE
// - Receive end of the board-to-board serial link. Runs on the second DE2 board's 10 MHz clock.
// - Deserialises the 18-bit switch word that the transmitter sends LSB-first on a data line framed by a dflag line.
// - Presents the last good word in parallel for LEDs/HEX display, with a one-cycle valid strobe, an error strobe and a frame counter.
// PARAMETERS
// - FRAME_BITS   18  number of data bits per frame; the frame is dflag high for exactly this many cycles.
// - SYNC_STAGES  2   flip-flop synchroniser depth applied to both incoming lines (min 2).
// - CNT_WIDTH    8   width of the good-frame counter.
// PORTS
// - Ten_MHz_input  in   1           10 MHz system clock; all logic on the posedge.
// - reset_n        in   1           synchronous, active-low reset.
// - data_in_1_bit  in   1           serial data from the other board, asynchronous, LSB first.
// - dflag_in       in   1           frame flag from the other board, asynchronous; high while bits are sent.
// - data_out       out  FRAME_BITS  last correctly received word; holds until the next good frame.
// - data_valid     out  1           one-cycle pulse when data_out has just been updated.
// - frame_error    out  1           one-cycle pulse when a frame is rejected (short or overlong).
// - frame_count    out  CNT_WIDTH   number of good frames received; wraps from all-ones to 0.
// - busy           out  1           high while the FSM is in SHIFT or DRAIN.
// BEHAVIOUR
// - Reset (reset_n=0 sampled at posedge):
//   - Outputs: data_out=0, data_valid=0, frame_error=0, frame_count=0, busy=0.
//   - Internal: shift register and bit counter cleared, synchroniser flops cleared, FSM to IDLE.
// - Synchronisation: data_in_1_bit and dflag_in each pass through an identical SYNC_STAGES-deep chain (data_s, dflag_s).
//   - Equal depth keeps bits aligned with the flag.
//   - All FSM decisions use data_s and dflag_s only.
// - Bit numbering: the first bit of a frame is bit 0.
//   - Right-shift insert: sh <= {data_s, sh[FRAME_BITS-1:1]}.
//   - After FRAME_BITS shifts, the first bit sent sits in sh[0].
// - Bit counter: bit_cnt is $clog2(FRAME_BITS+1) bits wide and saturates at FRAME_BITS.
// - FSM states: IDLE, SHIFT, DRAIN.
//   - IDLE:
//     - dflag_s=1: shift in data_s, bit_cnt<=1, go to SHIFT.
//     - Otherwise: stay in IDLE.
//   - SHIFT, dflag_s=1 and bit_cnt<FRAME_BITS: shift in data_s, bit_cnt++.
//   - SHIFT, dflag_s=1 and bit_cnt==FRAME_BITS: overlong frame; pulse frame_error next cycle, go to DRAIN, no shift.
//   - SHIFT, dflag_s=0 and bit_cnt==FRAME_BITS: next cycle data_out<=sh, data_valid=1, frame_count++; go to IDLE.
//   - SHIFT, dflag_s=0 and bit_cnt<FRAME_BITS: short frame; next cycle frame_error=1, data_out unchanged; go to IDLE.
//   - DRAIN: ignore data until dflag_s=0, then go to IDLE. No second error pulse.
// - Latency: data_valid rises SYNC_STAGES+1 clocks after the first posedge that samples raw dflag_in low at end of frame.
// - Exclusivity: data_valid and frame_error are never high in the same cycle. Each is exactly one cycle wide.
// - busy=1 in SHIFT and DRAIN, 0 in IDLE (registered with the state).
// - Back-to-back frames: a frame may start in the cycle right after the data_valid cycle. A single low cycle of dflag_s between frames is enough.
// - Reset released while dflag_s=1: go to DRAIN, not SHIFT, so a partial frame is never captured.
// - Reset asserted mid-frame: the frame is abandoned with no error pulse.
// - frame_count counts good frames only; it wraps modulo 2^CNT_WIDTH.
// TESTING
// - Word 18'h2A5C3, dflag high 18 cycles, LSB first, then low -> data_valid one pulse at SYNC_STAGES+1 clocks after fall; data_out=18'h2A5C3; frame_count=1.
// - 17-bit frame after a good 18'h00001 -> frame_error one pulse; data_out stays 18'h00001; frame_count unchanged.
// - 20-cycle dflag with data -> frame_error pulses once after bit 18 is seen; busy stays high until dflag low; data_out unchanged.
// - Frames 18'h3FFFF then 18'h00000 separated by 1 low cycle -> two data_valid pulses; data_out ends 0; frame_count=2.
// - reset_n low at bit 9, released with dflag still high -> FSM in DRAIN, no valid/error; next clean frame 18'h15555 received correctly.
// - 256 good frames with CNT_WIDTH=8 -> frame_count wraps to 0; data_valid count = 256.

Source files
------------

// File: rtl/data_receiver_if.sv
// Board-to-board serial link bundle: the two asynchronous serial lines from the
// far board plus the parallel result seen by the LED/HEX display logic.
// master = link source / display consumer, slave = the receiver.
interface data_receiver_if #(
   parameter int FRAME_BITS = 18,
   parameter int CNT_WIDTH  = 8
);
   logic                  data_in_1_bit;
   logic                  dflag_in;
   logic [FRAME_BITS-1:0] data_out;
   logic                  data_valid;
   logic                  frame_error;
   logic [CNT_WIDTH-1:0]  frame_count;
   logic                  busy;

   modport master (
      output data_in_1_bit,
      output dflag_in,
      input  data_out,
      input  data_valid,
      input  frame_error,
      input  frame_count,
      input  busy
   );

   modport slave (
      input  data_in_1_bit,
      input  dflag_in,
      output data_out,
      output data_valid,
      output frame_error,
      output frame_count,
      output busy
   );
endinterface

// File: rtl/data_receiver.sv
// Receive end of the board-to-board serial link. Synchronises the serial data
// and frame flag, deserialises LSB-first frames of FRAME_BITS bits and presents
// the last good word with valid/error strobes and a good-frame counter.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for dflag_s high; also arms the receiver after reset
// SHIFT | collecting bits while dflag_s is high
// DRAIN | rejected or partial frame; wait for dflag_s low, no capture
module data_receiver #(
   parameter int FRAME_BITS  = 18,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 8
) (
   input logic             Ten_MHz_input,
   input logic             reset_n,
   data_receiver_if.slave  link
);

   localparam int BW = $clog2(FRAME_BITS + 1);
   localparam int FW = $clog2(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] data_sync_q;
   logic [SYNC_STAGES-1:0] dflag_sync_q;
   logic                   data_s;
   logic                   dflag_s;

   state_t                 state_q;
   logic [FRAME_BITS-1:0]  sh_q;
   logic [BW-1:0]          bit_cnt_q;
   logic [FRAME_BITS-1:0]  data_out_q;
   logic                   data_valid_q;
   logic                   frame_error_q;
   logic [CNT_WIDTH-1:0]   frame_count_q;
   logic                   busy_q;
   logic                   good_pend_q;
   logic                   bad_pend_q;
   logic [FW-1:0]          fill_q;
   logic                   armed_q;

   // Equal-depth synchronisers keep each data bit aligned with its flag.
   always_ff @(posedge Ten_MHz_input) begin
      if (!reset_n) begin
         data_sync_q  <= '0;
         dflag_sync_q <= '0;
      end else begin
         data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], link.data_in_1_bit};
         dflag_sync_q <= {dflag_sync_q[SYNC_STAGES-2:0], link.dflag_in};
      end
   end

   assign data_s  = data_sync_q[SYNC_STAGES-1];
   assign dflag_s = dflag_sync_q[SYNC_STAGES-1];

   // Frame FSM with registered strobes. The frame outcome is first latched in
   // a pending flag and published one clock later, so data_valid lands
   // SYNC_STAGES+1 clocks after the raw flag is first sampled low.
   // After reset the FSM waits for the synchroniser to refill (fill_q
   // down-counter) and, if the flag is already high, drains that frame.
   always_ff @(posedge Ten_MHz_input) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         sh_q          <= '0;
         bit_cnt_q     <= '0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
         frame_count_q <= '0;
         busy_q        <= 1'b0;
         good_pend_q   <= 1'b0;
         bad_pend_q    <= 1'b0;
         fill_q        <= FW'(SYNC_STAGES);
         armed_q       <= 1'b0;
      end else begin
         data_valid_q  <= good_pend_q;
         frame_error_q <= bad_pend_q;
         good_pend_q   <= 1'b0;
         bad_pend_q    <= 1'b0;

         if (good_pend_q) begin
            data_out_q    <= sh_q;
            frame_count_q <= frame_count_q + 1'b1;
         end

         if (fill_q != '0) begin
            fill_q <= fill_q - 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (fill_q == '0) begin
                  if (!armed_q) begin
                     armed_q <= 1'b1;
                     if (dflag_s) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                     end
                  end else if (dflag_s) begin
                     sh_q      <= {data_s, sh_q[FRAME_BITS-1:1]};
                     bit_cnt_q <= BW'(1);
                     state_q   <= SHIFT;
                     busy_q    <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (dflag_s) begin
                  if (bit_cnt_q == BW'(FRAME_BITS)) begin
                     bad_pend_q <= 1'b1;
                     state_q    <= DRAIN;
                  end else begin
                     sh_q      <= {data_s, sh_q[FRAME_BITS-1:1]};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else begin
                  if (bit_cnt_q == BW'(FRAME_BITS)) begin
                     good_pend_q <= 1'b1;
                  end else begin
                     bad_pend_q <= 1'b1;
                  end
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            DRAIN: begin
               if (!dflag_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign link.data_out    = data_out_q;
   assign link.data_valid  = data_valid_q;
   assign link.frame_error = frame_error_q;
   assign link.frame_count = frame_count_q;
   assign link.busy        = busy_q;

endmodule

// File: tb/tb_data_receiver.sv
// Bench for data_receiver: frames are generated with known lengths and words;
// a frame-level model decides the outcome and queues it, and a negedge monitor
// checks every strobe the receiver produces against the queue.
module tb_data_receiver;
   localparam int FB = 18;
   localparam int SS = 2;
   localparam int CW = 8;

   typedef struct {
      bit            good;
      logic [FB-1:0] data;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   data_receiver_if #(.FRAME_BITS(FB), .CNT_WIDTH(CW)) link ();

   data_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(SS), .CNT_WIDTH(CW)) dut (
      .Ten_MHz_input (clk),
      .reset_n       (rst_n),
      .link          (link.slave)
   );

   always #50 clk = ~clk;

   exp_t          sb[$];
   exp_t          mon_e;
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            last_fall = 0;
   int            n_valid = 0;
   logic          prev_pulse = 1'b0;
   logic [FB-1:0] m_data = '0;
   logic [CW-1:0] m_cnt = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: a frame is good only if the flag stays high for exactly FB cycles.
   task automatic send(input logic [FB-1:0] w, input int len, input int gap);
      exp_t e;
      if (len == FB) begin
         m_data = w;
         m_cnt  = m_cnt + 1'b1;
         e.good = 1'b1;
      end else begin
         e.good = 1'b0;
      end
      e.data = m_data;
      e.cnt  = m_cnt;
      sb.push_back(e);
      for (int i = 0; i < len; i++) begin
         link.dflag_in      = 1'b1;
         link.data_in_1_bit = (i < FB) ? w[i] : 1'($urandom);
         tick();
      end
      link.dflag_in      = 1'b0;
      link.data_in_1_bit = 1'($urandom);
      last_fall          = cyc + 1;
      for (int g = 0; g < gap; g++) begin
         tick();
         link.data_in_1_bit = 1'($urandom);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         if (link.data_valid || link.frame_error) begin
            chk("exclusive", longint'(link.data_valid & link.frame_error), 0);
            chk("pulse_width", longint'(prev_pulse), 0);
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_strobe: got valid=%0b error=%0b expected none", link.data_valid, link.frame_error);
            end else begin
               mon_e = sb.pop_front();
               chk("kind_valid", longint'(link.data_valid), longint'(mon_e.good));
               chk("data_out", longint'(link.data_out), longint'(mon_e.data));
               chk("frame_count", longint'(link.frame_count), longint'(mon_e.cnt));
               if (mon_e.good) chk("latency", longint'(cyc - last_fall), SS + 1);
            end
            if (link.data_valid) n_valid++;
         end
         prev_pulse = link.data_valid | link.frame_error;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   initial begin
      logic [FB-1:0] w;
      int            r;
      int            len;
      link.dflag_in      = 1'b0;
      link.data_in_1_bit = 1'b0;
      rst_n              = 1'b0;
      repeat (4) tick();
      chk("rst_data_out", longint'(link.data_out), 0);
      chk("rst_valid", longint'(link.data_valid), 0);
      chk("rst_error", longint'(link.frame_error), 0);
      chk("rst_count", longint'(link.frame_count), 0);
      chk("rst_busy", longint'(link.busy), 0);
      rst_n = 1'b1;
      repeat (6) tick();

      send(18'h2A5C3, FB, 6);
      chk("word1_out", longint'(link.data_out), 'h2A5C3);
      chk("word1_count", longint'(link.frame_count), 1);

      send(18'h00001, FB, 3);
      send(18'h3FFFF, 17, 6);
      chk("short_keeps_out", longint'(link.data_out), 'h00001);

      send(18'h15A5A, 20, 1);
      chk("overlong_busy_hi", longint'(link.busy), 1);
      repeat (4) tick();
      chk("overlong_busy_lo", longint'(link.busy), 0);
      repeat (4) tick();

      send(18'h3FFFF, FB, 1);
      send(18'h00000, FB, 6);
      chk("b2b_out", longint'(link.data_out), 0);

      for (int k = 0; k < 40; k++) begin
         w = FB'($urandom);
         r = int'($urandom_range(0, 3));
         if (r == 0)      len = int'($urandom_range(10, 17));
         else if (r == 1) len = int'($urandom_range(19, 22));
         else             len = FB;
         send(w, len, int'($urandom_range(1, 4)));
      end
      repeat (10) tick();

      // Reset in the middle of a frame, released while the flag is still high.
      w = 18'h2A5C3;
      for (int i = 0; i < 9; i++) begin
         link.dflag_in      = 1'b1;
         link.data_in_1_bit = w[i];
         tick();
      end
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n  = 1'b1;
      m_data = '0;
      m_cnt  = '0;
      repeat (SS + 2) tick();
      chk("midrst_busy", longint'(link.busy), 1);
      chk("midrst_out", longint'(link.data_out), 0);
      chk("midrst_count", longint'(link.frame_count), 0);
      repeat (5) tick();
      link.dflag_in = 1'b0;
      repeat (4) tick();
      send(18'h15555, FB, 6);
      chk("post_rst_out", longint'(link.data_out), 'h15555);
      chk("post_rst_count", longint'(link.frame_count), 1);
      repeat (6) tick();

      // Counter wrap: 256 good frames from a fresh reset.
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n   = 1'b1;
      m_data  = '0;
      m_cnt   = '0;
      n_valid = 0;
      repeat (6) tick();
      for (int k = 0; k < 256; k++) begin
         send(FB'($urandom), FB, int'($urandom_range(1, 3)));
      end
      repeat (10) tick();
      chk("wrap_count", longint'(link.frame_count), 0);
      chk("valid_pulses", longint'(n_valid), 256);

      repeat (10) tick();
      chk("sb_drained", longint'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
